// File: rtl/tqvp_vga_frame_monitor_pkg.sv
// Shared constants and types for the VGA frame monitor peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tqvp_vga_frame_monitor_pkg;

   // Counter widths
   localparam int H_W     = 16;
   localparam int L_W     = 12;
   localparam int FC_W    = 16;
   localparam int PROBE_W = 11;

   // Register map (byte addresses on the TinyQV peripheral bus)
   localparam logic [5:0] MON_CTRL        = 6'h00;
   localparam logic [5:0] MON_STATUS      = 6'h04;
   localparam logic [5:0] MON_HPERIOD     = 6'h08;
   localparam logic [5:0] MON_VLINES      = 6'h0C;
   localparam logic [5:0] MON_FRAME_COUNT = 6'h10;
   localparam logic [5:0] MON_FRAME_SUM   = 6'h14;
   localparam logic [5:0] MON_PROBE_XY    = 6'h18;
   localparam logic [5:0] MON_PROBE_PIX   = 6'h1C;

   // CTRL bit positions
   localparam int CTRL_EN        = 0;
   localparam int CTRL_IE_FRAME  = 1;
   localparam int CTRL_IE_CHANGE = 2;

   // STATUS bit positions
   localparam int ST_FRAME_DONE    = 0;
   localparam int ST_TIMING_CHANGE = 1;
   localparam int ST_PROBE_VALID   = 2;

   // Captured probe pixel as it appears in PROBE_PIX
   typedef struct packed {
      logic       vld;
      logic [5:0] rgb;
   } probe_pix_t;

   // One step of the frame signature: rotate left by one, fold in the pixel
   function automatic logic [31:0] sig_step(input logic [31:0] acc, input logic [5:0] rgb);
      return {acc[30:0], acc[31]} ^ {26'b0, rgb};
   endfunction

endpackage

// File: rtl/tqvp_vga_frame_monitor_sync_measure.sv
// Sync edge detection, line/frame geometry counters and timing-change detection.
// Latency: measured values update one cycle after the sampled sync edge; edge flags are combinational.
// Backpressure: none; consumes one pixel per cycle unconditionally.
module vga_sync_measure
   import tqvp_vga_frame_monitor_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   input  logic           i_hsync,
   input  logic           i_vsync,
   output logic           o_vs_rise,
   output logic [H_W-1:0] o_h_cnt,
   output logic [L_W-1:0] o_l_cnt,
   output logic [H_W-1:0] o_hperiod,
   output logic [L_W-1:0] o_vlines,
   output logic           o_change
);
   logic           r_hs_prev, r_vs_prev;
   logic [H_W-1:0] r_h_cnt, r_hperiod;
   logic [L_W-1:0] r_l_cnt, r_vlines;
   logic           w_hs_rise, w_vs_rise;

   assign w_hs_rise = i_hsync & ~r_hs_prev;
   assign w_vs_rise = i_vsync & ~r_vs_prev;

   // A differing new measurement only counts as a change once a real (nonzero) one exists
   assign o_change = i_en & ((w_hs_rise & (r_hperiod != '0) & (r_h_cnt != r_hperiod)) |
                             (w_vs_rise & (r_vlines != '0) & (r_l_cnt != r_vlines)));

   assign o_vs_rise = w_vs_rise;
   assign o_h_cnt   = r_h_cnt;
   assign o_l_cnt   = r_l_cnt;
   assign o_hperiod = r_hperiod;
   assign o_vlines  = r_vlines;

   // Previous sync levels track the input regardless of enable, so enabling never fakes an edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hs_prev <= 1'b0;
         r_vs_prev <= 1'b0;
      end else begin
         r_hs_prev <= i_hsync;
         r_vs_prev <= i_vsync;
      end
   end

   // Pixel and line counters with period/line-count latching on sync rises
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_h_cnt   <= '0;
         r_hperiod <= '0;
         r_l_cnt   <= '0;
         r_vlines  <= '0;
      end else if (i_en) begin
         if (w_hs_rise) begin
            r_hperiod <= r_h_cnt;
            r_h_cnt   <= H_W'(1);
         end else if (r_h_cnt != '1) begin
            r_h_cnt <= r_h_cnt + H_W'(1);
         end

         if (w_vs_rise) begin
            r_vlines <= r_l_cnt;
            r_l_cnt  <= w_hs_rise ? L_W'(1) : '0;
         end else if (w_hs_rise && (r_l_cnt != '1)) begin
            r_l_cnt <= r_l_cnt + L_W'(1);
         end
      end
   end

endmodule

// File: rtl/tqvp_vga_frame_monitor.sv
// TinyQV responder measuring an incoming PMOD VGA stream: timing, frame signature, pixel probe, IRQ.
// Latency: state updates one cycle after the sampled pixel; register reads are combinational.
// Backpressure: none; data_ready is tied high and every pixel is consumed.
module tqvp_vga_frame_monitor
   import tqvp_vga_frame_monitor_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);
   logic               w_en, w_wr, w_vs_rise, w_change, w_probe_hit, w_unused;
   logic [5:0]         w_rgb;
   logic [H_W-1:0]     w_h_cnt, w_hperiod;
   logic [L_W-1:0]     w_l_cnt, w_vlines;

   logic [2:0]         r_ctrl;
   logic               r_frame_done, r_timing_change;
   logic [FC_W-1:0]    r_frame_count;
   logic [31:0]        r_acc, r_frame_sum;
   logic [PROBE_W-1:0] r_probe_x, r_probe_y;
   probe_pix_t         r_probe;

   assign w_en     = r_ctrl[CTRL_EN];
   assign w_wr     = (data_write_n != 2'b11);
   assign w_rgb    = ui_in[5:0];
   assign w_unused = &{1'b0, data_read_n, data_in[31:27], data_in[15:11]};

   assign uo_out     = 8'h00;
   assign data_ready = 1'b1;

   vga_sync_measure u_sync (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_en      (w_en),
      .i_hsync   (ui_in[6]),
      .i_vsync   (ui_in[7]),
      .o_vs_rise (w_vs_rise),
      .o_h_cnt   (w_h_cnt),
      .o_l_cnt   (w_l_cnt),
      .o_hperiod (w_hperiod),
      .o_vlines  (w_vlines),
      .o_change  (w_change)
   );

   // The frame-boundary cycle belongs to no frame, so it never captures a probe pixel
   assign w_probe_hit = w_en & ~w_vs_rise & ~r_probe.vld &
                        (w_h_cnt == H_W'(r_probe_x)) & (w_l_cnt == L_W'(r_probe_y));

   // Software-written configuration
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl    <= '0;
         r_probe_x <= '0;
         r_probe_y <= '0;
      end else if (w_wr) begin
         if (address == MON_CTRL) r_ctrl <= data_in[2:0];
         if (address == MON_PROBE_XY) begin
            r_probe_x <= data_in[10:0];
            r_probe_y <= data_in[26:16];
         end
      end
   end

   // Sticky status flags: W1C from software, hardware set takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_done    <= 1'b0;
         r_timing_change <= 1'b0;
      end else begin
         r_frame_done    <= (r_frame_done & ~(w_wr & (address == MON_STATUS) & data_in[ST_FRAME_DONE]))
                            | (w_en & w_vs_rise);
         r_timing_change <= (r_timing_change & ~(w_wr & (address == MON_STATUS) & data_in[ST_TIMING_CHANGE]))
                            | w_change;
      end
   end

   // Frame signature and frame counter, latched at each vsync rise
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc         <= '0;
         r_frame_sum   <= '0;
         r_frame_count <= '0;
      end else if (w_en) begin
         if (w_vs_rise) begin
            r_frame_sum   <= r_acc;
            r_acc         <= {26'b0, w_rgb};
            r_frame_count <= r_frame_count + FC_W'(1);
         end else begin
            r_acc <= sig_step(r_acc, w_rgb);
         end
      end
   end

   // Pixel probe: first hit per frame; re-armed by a new frame or a new position
   always_ff @(posedge clk) begin
      if (rst) begin
         r_probe <= '0;
      end else if (w_wr && (address == MON_PROBE_XY)) begin
         r_probe.vld <= 1'b0;
      end else if (w_en && w_vs_rise) begin
         r_probe.vld <= 1'b0;
      end else if (w_probe_hit) begin
         r_probe.vld <= 1'b1;
         r_probe.rgb <= w_rgb;
      end
   end

   assign user_interrupt = (r_frame_done & r_ctrl[CTRL_IE_FRAME]) |
                           (r_timing_change & r_ctrl[CTRL_IE_CHANGE]);

   // Combinational read mux; unmapped addresses read zero
   always_comb begin
      data_out = 32'h0;
      case (address)
         MON_CTRL:        data_out = {29'b0, r_ctrl};
         MON_STATUS:      data_out = {29'b0, r_probe.vld, r_timing_change, r_frame_done};
         MON_HPERIOD:     data_out = {16'b0, w_hperiod};
         MON_VLINES:      data_out = {20'b0, w_vlines};
         MON_FRAME_COUNT: data_out = {16'b0, r_frame_count};
         MON_FRAME_SUM:   data_out = r_frame_sum;
         MON_PROBE_XY:    data_out = {5'b0, r_probe_y, 5'b0, r_probe_x};
         MON_PROBE_PIX:   data_out = {25'b0, r_probe};
         default:         data_out = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_tqvp_vga_frame_monitor.sv
// Bench for the VGA frame monitor: synthetic sync stream plus bus reads checked through a scoreboard.
// Latency: each check observes registers as left by the previous rising edge.
// Backpressure: n/a.
module tb_tqvp_vga_frame_monitor;
   import tqvp_vga_frame_monitor_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  ui_in = 8'h00;
   logic [7:0]  uo_out;
   logic [5:0]  address = 6'h00;
   logic [31:0] data_in = 32'h0;
   logic [1:0]  data_write_n = 2'b11;
   logic [1:0]  data_read_n = 2'b11;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   tqvp_vga_frame_monitor dut (
      .clk            (clk),
      .rst            (rst),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .address        (address),
      .data_in        (data_in),
      .data_write_n   (data_write_n),
      .data_read_n    (data_read_n),
      .data_out       (data_out),
      .data_ready     (data_ready),
      .user_interrupt (user_interrupt)
   );

   always #5 clk = ~clk;

   // Scoreboard: expected responses queued by the driver, popped by the monitor
   string       nq[$];
   logic [31:0] eq[$];
   logic [31:0] mq[$];
   int          kq[$];
   logic        chk_vld = 1'b0;
   int          nerr = 0;
   int          nchk = 0;

   // Stream generator state
   localparam int V = 10;
   int          hper = 20;
   int          col = 0, line = 0, sp = 0, sleft = 0;
   int          spot_p[2];
   logic [5:0]  spot_rgb[2];
   logic [7:0]  idle_ui = 8'h00;
   logic        rst_nxt = 1'b1;

   // Monitor: compare whatever the DUT presents in cycles flagged for checking
   always @(negedge clk) begin
      string       nm;
      logic [31:0] act, ex, mk;
      int          kd;
      #1;
      if (chk_vld) begin
         if (kq.size() == 0) begin
            nerr++;
            nchk++;
            $display("FAIL scoreboard_empty: got a check strobe, required a queued expectation");
         end else begin
            nm = nq.pop_front();
            ex = eq.pop_front();
            mk = mq.pop_front();
            kd = kq.pop_front();
            case (kd)
               0:       act = data_out;
               1:       act = {31'b0, user_interrupt};
               default: act = {23'b0, data_ready, uo_out};
            endcase
            act = act & mk;
            nchk++;
            if (act !== ex) begin
               nerr++;
               $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, ex);
            end
         end
      end
   end

   // One bus/stream cycle; kind < 0 means no check this cycle
   task automatic cyc(input bit w, input logic [5:0] a, input logic [31:0] d,
                      input int kind, input string nm, input logic [31:0] ex, input logic [31:0] mk);
      logic [5:0] px;
      px = 6'h00;
      @(negedge clk);
      rst = rst_nxt;
      if (sleft > 0) begin
         for (int i = 0; i < 2; i++) if (spot_p[i] == sp) px = spot_rgb[i];
         ui_in = {(line == 0) && (col < 2), (col < 2), px};
         sp++;
         sleft--;
         col++;
         if (col == hper) begin
            col  = 0;
            line = (line == V - 1) ? 0 : line + 1;
         end
      end else begin
         ui_in = idle_ui;
      end
      address      = a;
      data_in      = d;
      data_write_n = w ? 2'b00 : 2'b11;
      chk_vld      = (kind >= 0);
      if (kind >= 0) begin
         nq.push_back(nm);
         eq.push_back(ex);
         mq.push_back(mk);
         kq.push_back(kind);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) cyc(1'b0, 6'h00, 32'h0, -1, "", 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      cyc(1'b1, a, d, -1, "", 32'h0, 32'h0);
   endtask

   task automatic chk(input string nm, input logic [5:0] a, input logic [31:0] ex,
                      input logic [31:0] mk = 32'hFFFF_FFFF);
      cyc(1'b0, a, 32'h0, 0, nm, ex, mk);
   endtask

   task automatic chk_irq(input string nm, input logic ex);
      cyc(1'b0, 6'h00, 32'h0, 1, nm, {31'b0, ex}, 32'h1);
   endtask

   task automatic restart();
      sleft   = 0;
      idle_ui = 8'h00;
      rst_nxt = 1'b1;
      tick(2);
      rst_nxt = 1'b0;
   endtask

   // Start a fresh stream at frame start; the next cycle carries the first vsync/hsync rise
   task automatic go(input int n);
      hper = 20; col = 0; line = 0; sp = 0; sleft = n;
      spot_p[0] = -1; spot_p[1] = -1;
      spot_rgb[0] = 6'h00; spot_rgb[1] = 6'h00;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before the end of the stimulus");
      $fatal(1);
   end

   initial begin
      spot_p[0] = -1; spot_p[1] = -1;
      spot_rgb[0] = 6'h00; spot_rgb[1] = 6'h00;

      // Reset state and bus basics
      restart();
      chk("rst_ctrl", MON_CTRL, 32'h0);
      chk("rst_status", MON_STATUS, 32'h0);
      chk("rst_hperiod", MON_HPERIOD, 32'h0);
      chk("rst_vlines", MON_VLINES, 32'h0);
      chk("rst_fcount", MON_FRAME_COUNT, 32'h0);
      chk("rst_fsum", MON_FRAME_SUM, 32'h0);
      chk("rst_pxy", MON_PROBE_XY, 32'h0);
      chk("rst_ppix", MON_PROBE_PIX, 32'h0);
      chk_irq("rst_irq", 1'b0);
      cyc(1'b0, 6'h00, 32'h0, 2, "const_outputs", 32'h0000_0100, 32'hFFFF_FFFF);
      wr(6'h20, 32'hFFFF_FFFF);
      chk("unmapped_read", 6'h20, 32'h0);
      chk("ctrl_untouched", MON_CTRL, 32'h0);
      wr(MON_PROBE_XY, 32'hFFFF_FFFF);
      chk("pxy_mask", MON_PROBE_XY, 32'h07FF_07FF);

      // Steady timing: 20 clocks per line, 10 lines, rgb 0, three frames
      restart();
      wr(MON_CTRL, 32'h1);
      go(600);
      tick(600);
      chk("t1_hperiod", MON_HPERIOD, 32'd20);
      chk("t1_vlines", MON_VLINES, 32'd10);
      chk("t1_fcount", MON_FRAME_COUNT, 32'd3);
      chk("t1_fsum", MON_FRAME_SUM, 32'h0);
      chk("t1_status", MON_STATUS, 32'h1, 32'h3);

      // Signature: single pixel of 1, rotated by the cycles left before the next vsync rise
      restart();
      wr(MON_CTRL, 32'h1);
      go(600);
      spot_p[0] = 150; spot_rgb[0] = 6'h01;   // 49 cycles remain -> rotl 17
      spot_p[1] = 395; spot_rgb[1] = 6'h01;   // 4 cycles remain  -> rotl 4
      tick(210);
      chk("t2_fsum_rot17", MON_FRAME_SUM, 32'h0002_0000);
      tick(400);
      chk("t2_fsum_rot4", MON_FRAME_SUM, 32'h0000_0010);
      chk("t2_fcount", MON_FRAME_COUNT, 32'd3);

      // Probe at x=5, y=3 (line 2, column 5 of each frame)
      restart();
      wr(MON_PROBE_XY, 32'h0003_0005);
      wr(MON_CTRL, 32'h1);
      go(300);
      spot_p[0] = 45; spot_rgb[0] = 6'h2A;
      tick(100);
      chk("t3_ppix_hit", MON_PROBE_PIX, 32'h6A);
      chk("t3_status_valid", MON_STATUS, 32'h5, 32'h7);
      tick(103);
      chk("t3_ppix_cleared", MON_PROBE_PIX, 32'h2A);
      tick(50);
      chk("t3_ppix_rehit", MON_PROBE_PIX, 32'h40);
      tick(50);
      wr(MON_PROBE_XY, 32'h0003_0005);
      chk("t3_ppix_wr_clear", MON_PROBE_PIX, 32'h00);

      // Line period changes 20 -> 24 mid-run with IE_CHANGE
      restart();
      wr(MON_CTRL, 32'h5);
      go(300);
      tick(210);
      chk("t4_no_change_yet", MON_STATUS, 32'h1, 32'h3);
      hper = 24;
      tick(30);
      chk("t4_change_set", MON_STATUS, 32'h3, 32'h3);
      chk_irq("t4_irq_set", 1'b1);
      wr(MON_STATUS, 32'h2);
      chk("t4_change_clr", MON_STATUS, 32'h1, 32'h3);
      chk_irq("t4_irq_clr", 1'b0);
      chk("t4_hperiod", MON_HPERIOD, 32'd24);
      tick(60);

      // Frame interrupt timing and set-wins-over-W1C
      restart();
      wr(MON_CTRL, 32'h3);
      go(210);
      chk_irq("t5_irq_in_vs_cycle", 1'b0);
      chk_irq("t5_irq_after_vs", 1'b1);
      wr(MON_STATUS, 32'h1);
      chk("t5_fd_cleared", MON_STATUS, 32'h0, 32'h1);
      chk_irq("t5_irq_cleared", 1'b0);
      tick(195);
      wr(MON_STATUS, 32'h1);                  // same cycle as the second vsync rise
      chk("t5_set_wins", MON_STATUS, 32'h1, 32'h1);
      chk_irq("t5_irq_again", 1'b1);
      wr(MON_CTRL, 32'h1);
      chk_irq("t5_irq_ie_off", 1'b0);
      chk("t5_fcount", MON_FRAME_COUNT, 32'd2);
      tick(10);

      // Reset mid-frame, edges with EN=0, then re-enable from a clean frame start
      restart();
      wr(MON_CTRL, 32'h1);
      go(600);
      tick(250);
      rst_nxt = 1'b1;
      tick(2);
      rst_nxt = 1'b0;
      tick(250);
      chk("t6_ctrl", MON_CTRL, 32'h0);
      chk("t6_status", MON_STATUS, 32'h0);
      chk("t6_hperiod", MON_HPERIOD, 32'h0);
      chk("t6_vlines", MON_VLINES, 32'h0);
      chk("t6_fcount", MON_FRAME_COUNT, 32'h0);
      chk("t6_fsum", MON_FRAME_SUM, 32'h0);
      chk("t6_ppix", MON_PROBE_PIX, 32'h0);
      chk_irq("t6_irq", 1'b0);
      sleft = 0;
      tick(2);
      wr(MON_CTRL, 32'h1);
      go(250);
      tick(210);
      chk("t6_first_frame_status", MON_STATUS, 32'h1, 32'h3);
      chk("t6_first_frame_fcount", MON_FRAME_COUNT, 32'd2);
      chk("t6_first_frame_vlines", MON_VLINES, 32'd10);
      chk("t6_first_frame_hperiod", MON_HPERIOD, 32'd20);
      tick(40);

      // Enabling while both syncs are already high must not register an edge
      wr(MON_CTRL, 32'h0);
      idle_ui = 8'hC0;
      tick(3);
      wr(MON_CTRL, 32'h1);
      tick(3);
      chk("t7_no_false_vs", MON_FRAME_COUNT, 32'd2);
      chk("t7_no_false_hs", MON_HPERIOD, 32'd20);
      idle_ui = 8'h00;
      tick(3);

      if (kq.size() != 0) begin
         nchk++;
         nerr++;
         $display("FAIL scoreboard_drain: got %0d unconsumed expectations required 0", kq.size());
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
